machine_timer: RTL and testbench
================================

# machine_timer

Memory-mapped RISC-V machine timer (mtime/mtimecmp) on the processor core's data-memory port, decoded alongside DMEM. It keeps a free-running 64-bit time counter with a programmable prescaler and raises a registered machine-timer-interrupt-pending line (o_mtip) for the trap logic. 32-bit software accesses go through byte strobes, the same way DMEM is written.

## Interface
Parameters:
- XLEN, 32: data/address width; only 32 is supported.
- PRESCALE, 1: core clocks per mtime increment; legal range 1..65535.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_sel  in  1  address decode hit for this block's 32-byte window.
- i_we  in  1  write enable, qualified by i_sel.
- i_addr  in  XLEN  byte address. Bits [4:2] select the register; all other bits are ignored.
- i_wdata  in  XLEN  write data.
- i_wstrb  in  XLEN/8  byte write strobes. Bit k enables byte k.
- o_rdata  out  XLEN  read data, combinational from i_addr.
- o_mtip  out  1  machine timer interrupt pending, registered.

## Operation
- Register map by word index i_addr[4:2]:
  - 0: MTIME_LO (mtime[31:0])
  - 1: MTIME_HI (mtime[63:32])
  - 2: MTIMECMP_LO
  - 3: MTIMECMP_HI
  - 4: CTRL, where bit0 = EN and bits [31:1] read 0
  - 5-7: reserved; read 0, writes ignored
- Reset values: mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, EN = 0, prescaler count = 0, o_mtip = 0.
- Reads:
  - o_rdata = selected register whenever i_sel = 1; o_rdata = 0 when i_sel = 0.
  - Reads have no side effects.
- Writes:
  - On a rising edge with i_sel & i_we, each byte k of the selected register with i_wstrb[k] = 1 takes i_wdata[8k+7:8k].
  - Bytes with a clear strobe are unchanged.
- Prescaler:
  - 16-bit count. While EN = 1, it counts 0..PRESCALE-1 and wraps to 0.
  - tick = EN & (count == PRESCALE-1). With PRESCALE = 1, tick = EN every cycle.
  - While EN = 0, count is held at 0.
- Increment: on tick, mtime <= mtime + 1 as a full 64-bit add (carry from LO into HI). Wraps from 2^64-1 to 0.
- Simultaneous write and tick:
  - A write to MTIME_LO or MTIME_HI wins over the increment for the whole 64-bit mtime. That cycle's tick is dropped and the unwritten half is held.
  - The prescaler still advances.
- Writing CTRL.EN 1->0 clears the prescaler count on the same edge.
- Compare: o_mtip <= (mtime >= mtimecmp), unsigned 64-bit, using the register values before the edge. The compare is level-sensitive; software clears o_mtip by raising mtimecmp.
- Writes to mtimecmp or CTRL do not affect the tick of the same cycle.

## Timing
- Read latency: 0 cycles (combinational). This suits the single-cycle core, which consumes load data in the same cycle.
- Write latency: the new value is visible on o_rdata the cycle after the write edge.
- o_mtip lags the register state by one cycle: if the condition first holds after edge n, o_mtip rises after edge n+1.
- With EN = 1, PRESCALE = P and no writes, mtime increments exactly once every P cycles. The first increment comes P edges after EN is set.
- Asynchronous reset mid-count: all state, including o_mtip, returns to reset values immediately, independent of i_clk.
- Software writing 64-bit mtimecmp must write HI = FFFF_FFFF first, then LO, then HI, to avoid spurious o_mtip. The hardware adds no atomicity.

## Test plan
- Reset values:
  - Assert i_rst between clock edges -> o_mtip = 0 immediately.
  - After release: MTIME_LO/HI read 0, MTIMECMP_LO/HI read FFFF_FFFF, CTRL reads 0.
  - mtime stays 0 for 20 cycles with EN = 0.
- Prescaler (PRESCALE = 4):
  - Write CTRL = 1 -> mtime reads 1 after 4 edges and 5 after 20 edges.
  - Write CTRL = 0 -> mtime freezes.
  - Re-enable -> the next increment comes exactly 4 edges later.
- Carry and wrap:
  - Write MTIME_LO = FFFF_FFFF and MTIME_HI = 0, EN = 1, PRESCALE = 1 -> next cycle reads LO = 0, HI = 1.
  - Preset both halves to FFFF_FFFF -> wraps to 0/0.
- Write/tick collision and strobes:
  - With EN = 1 and PRESCALE = 1, write MTIME_LO = 0000_0010 with wstrb = 4'b0001 when mtime = 0000_0100 -> reads 0000_0110.
  - HI is unchanged and there is no increment that cycle.
- Interrupt:
  - Write mtimecmp = 10, then mtime = 0, EN = 1, PRESCALE = 1 -> o_mtip rises exactly one cycle after mtime becomes 10.
  - Write MTIMECMP_LO = 100 -> o_mtip falls one cycle later.
- Decode:
  - Writes with i_sel = 0, or to offset 0x14, leave every register unchanged.
  - Reads of offsets 0x14-0x1C and reads with i_sel = 0 return 0.

Source files
------------

// File: rtl/machine_timer.sv
// machine_timer: RISC-V style mtime/mtimecmp block on the core data-memory port.
// A 64-bit free-running counter advances on prescaler ticks. A registered
// compare against mtimecmp drives the machine timer interrupt pending line.
// Software reaches the registers through 32-bit byte-strobed accesses.
module machine_timer #(
    parameter int XLEN     = 32,
    parameter int PRESCALE = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sel,
    input  logic              i_we,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN/8-1:0] i_wstrb,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_mtip
);

    // Word indices inside the 32-byte window
    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_CTRL        = 3'd4;

    // Terminal prescaler count; a tick fires on the cycle that count reaches it
    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

    logic [2*XLEN-1:0] mtime_reg, mtime_next;
    logic [2*XLEN-1:0] mtimecmp_reg, mtimecmp_next;
    logic              en_reg, en_next;
    logic [15:0]       count_reg, count_next;
    logic              mtip_reg;

    logic [2:0]        reg_idx;
    logic              wr_en;
    logic              wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
    logic              tick;
    logic [XLEN-1:0]   wmask;
    logic              unused_addr_bits;

    assign reg_idx     = i_addr[4:2];
    assign wr_en       = i_sel & i_we;
    assign wr_mtime_lo = wr_en && (reg_idx == REG_MTIME_LO);
    assign wr_mtime_hi = wr_en && (reg_idx == REG_MTIME_HI);
    assign wr_cmp_lo   = wr_en && (reg_idx == REG_MTIMECMP_LO);
    assign wr_cmp_hi   = wr_en && (reg_idx == REG_MTIMECMP_HI);
    assign wr_ctrl     = wr_en && (reg_idx == REG_CTRL);

    // Only the word index participates in decode; the rest of the address is ignored
    assign unused_addr_bits = &{1'b0, i_addr[XLEN-1:5], i_addr[1:0]};

    // Expand byte strobes into a bit mask so every write is a simple merge
    generate
        for (genvar gi = 0; gi < XLEN / 8; gi++) begin : g_wmask
            assign wmask[8*gi +: 8] = {8{i_wstrb[gi]}};
        end
    endgenerate

    // Tick uses the enable and count as they stand before the edge,
    // so a same-cycle CTRL write never changes it
    assign tick = en_reg && (count_reg == PRESCALE_MAX);

    // Prescaler count: free-runs while enabled, parked at zero otherwise,
    // and cleared immediately when software drops EN
    always_comb begin
        count_next = '0;
        if (en_reg) begin
            count_next = tick ? 16'd0 : count_reg + 16'd1;
        end
        if (wr_ctrl && i_wstrb[0] && !i_wdata[0]) begin
            count_next = '0;
        end
    end

    // Enable bit only listens to byte lane 0
    always_comb begin
        en_next = en_reg;
        if (wr_ctrl && i_wstrb[0]) begin
            en_next = i_wdata[0];
        end
    end

    // mtime: a software write to either half wins over the tick for all 64 bits
    always_comb begin
        mtime_next = mtime_reg;
        if (wr_mtime_lo) begin
            mtime_next[XLEN-1:0] = (mtime_reg[XLEN-1:0] & ~wmask) | (i_wdata & wmask);
        end else if (wr_mtime_hi) begin
            mtime_next[2*XLEN-1:XLEN] = (mtime_reg[2*XLEN-1:XLEN] & ~wmask) | (i_wdata & wmask);
        end else if (tick) begin
            mtime_next = mtime_reg + 64'd1;
        end
    end

    // mtimecmp: plain byte-merged writes to either half
    always_comb begin
        mtimecmp_next = mtimecmp_reg;
        if (wr_cmp_lo) begin
            mtimecmp_next[XLEN-1:0] = (mtimecmp_reg[XLEN-1:0] & ~wmask) | (i_wdata & wmask);
        end
        if (wr_cmp_hi) begin
            mtimecmp_next[2*XLEN-1:XLEN] = (mtimecmp_reg[2*XLEN-1:XLEN] & ~wmask) | (i_wdata & wmask);
        end
    end

    // State registers; the interrupt compares the pre-edge register values
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mtime_reg    <= '0;
            mtimecmp_reg <= '1;
            en_reg       <= 1'b0;
            count_reg    <= '0;
            mtip_reg     <= 1'b0;
        end else begin
            mtime_reg    <= mtime_next;
            mtimecmp_reg <= mtimecmp_next;
            en_reg       <= en_next;
            count_reg    <= count_next;
            mtip_reg     <= (mtime_reg >= mtimecmp_reg);
        end
    end

    assign o_mtip = mtip_reg;

    // Zero-latency read mux; deselected or reserved slots return zero
    always_comb begin
        o_rdata = '0;
        if (i_sel) begin
            case (reg_idx)
                REG_MTIME_LO:    o_rdata = mtime_reg[XLEN-1:0];
                REG_MTIME_HI:    o_rdata = mtime_reg[2*XLEN-1:XLEN];
                REG_MTIMECMP_LO: o_rdata = mtimecmp_reg[XLEN-1:0];
                REG_MTIMECMP_HI: o_rdata = mtimecmp_reg[2*XLEN-1:XLEN];
                REG_CTRL:        o_rdata = {{(XLEN-1){1'b0}}, en_reg};
                default:         o_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Testbench for machine_timer: two instances (PRESCALE 4 and 1) share one bus.
// Reads push expected data into a scoreboard queue; a negedge monitor pops and
// compares, and also checks o_mtip every cycle against a behavioural model.
module tb_machine_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, we;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata4, rdata1;
    logic        mtip4, mtip1;

    always #5 clk = ~clk;

    machine_timer #(.XLEN(32), .PRESCALE(4)) u4 (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_wstrb(wstrb), .o_rdata(rdata4), .o_mtip(mtip4)
    );

    machine_timer #(.XLEN(32), .PRESCALE(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_wstrb(wstrb), .o_rdata(rdata1), .o_mtip(mtip1)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model (index 0: PRESCALE 4, index 1: PRESCALE 1)
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    logic        m_en    [2];
    int          m_cnt   [2];
    logic        m_mtip  [2];

    function automatic int presc(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (st[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_mtime[i] = 64'd0;
                m_cmp[i]   = 64'hFFFF_FFFF_FFFF_FFFF;
                m_en[i]    = 1'b0;
                m_cnt[i]   = 0;
                m_mtip[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic       w;
                logic       tk;
                int         ix;
                w  = sel && we;
                ix = int'(addr[4:2]);
                tk = m_en[i] && (m_cnt[i] == presc(i) - 1);
                m_mtip[i] = (m_mtime[i] >= m_cmp[i]);
                // prescaler
                if (m_en[i]) m_cnt[i] = (m_cnt[i] + 1) % presc(i);
                else         m_cnt[i] = 0;
                if (w && ix == 4 && wstrb[0] && !wdata[0]) m_cnt[i] = 0;
                // mtime
                if (w && ix == 0)
                    m_mtime[i] = {m_mtime[i][63:32], merge(m_mtime[i][31:0], wdata, wstrb)};
                else if (w && ix == 1)
                    m_mtime[i] = {merge(m_mtime[i][63:32], wdata, wstrb), m_mtime[i][31:0]};
                else if (tk)
                    m_mtime[i] = m_mtime[i] + 64'd1;
                // compare value and control
                if (w && ix == 2) m_cmp[i][31:0]  = merge(m_cmp[i][31:0], wdata, wstrb);
                if (w && ix == 3) m_cmp[i][63:32] = merge(m_cmp[i][63:32], wdata, wstrb);
                if (w && ix == 4 && wstrb[0]) m_en[i] = wdata[0];
            end
        end
    end

    function automatic logic [31:0] model_read(input int i, input logic [31:0] a, input logic s);
        if (!s) return 32'd0;
        case (a[4:2])
            3'd0:    return m_mtime[i][31:0];
            3'd1:    return m_mtime[i][63:32];
            3'd2:    return m_cmp[i][31:0];
            3'd3:    return m_cmp[i][63:32];
            3'd4:    return {31'd0, m_en[i]};
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- scoreboard
    typedef struct {
        string       name;
        logic [31:0] e4;
        logic [31:0] e1;
    } rd_t;

    rd_t  q[$];
    logic rd_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: interrupt line every cycle, read data whenever a read is on the bus
    always @(negedge clk) begin
        if (!rst) begin
            check("mtip_p4", {31'd0, mtip4}, {31'd0, m_mtip[0]});
            check("mtip_p1", {31'd0, mtip1}, {31'd0, m_mtip[1]});
            if (rd_active) begin
                if (q.size() == 0) begin
                    check("rd_queue_underflow", 32'd1, 32'd0);
                end else begin
                    rd_t e;
                    e = q.pop_front();
                    check({e.name, "_p4"}, rdata4, e.e4);
                    check({e.name, "_p1"}, rdata1, e.e1);
                    $display("read %s addr=%h p4=%h p1=%h", e.name, addr, rdata4, rdata1);
                end
            end
        end
    end

    // ---------------- driver tasks (each operation occupies one clock)
    task automatic op(input logic s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] st);
        sel = s; we = w; addr = a; wdata = d; wstrb = st;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        $display("write addr=%h data=%h strb=%b", a, d, st);
        op(1'b1, 1'b1, a, d, st);
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic rd_exp(input string name, input logic [31:0] a, input logic s,
                          input logic [31:0] e4, input logic [31:0] e1);
        rd_t e;
        e.name = name; e.e4 = e4; e.e1 = e1;
        q.push_back(e);
        rd_active = 1'b1;
        op(s, 1'b0, a, $urandom, 4'($urandom));
        rd_active = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic s);
        rd_exp(name, a, s, model_read(0, a, s), model_read(1, a, s));
    endtask

    task automatic chk_mtip(input string name, input logic e4, input logic e1);
        check({name, "_p4"}, {31'd0, mtip4}, {31'd0, e4});
        check({name, "_p1"}, {31'd0, mtip1}, {31'd0, e1});
    endtask

    task automatic reset_reads(input string tag);
        rd_exp({tag, "_lo"},    32'h00, 1'b1, 32'd0, 32'd0);
        rd_exp({tag, "_hi"},    32'h04, 1'b1, 32'd0, 32'd0);
        rd_exp({tag, "_cmplo"}, 32'h08, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_exp({tag, "_cmphi"}, 32'h0C, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_exp({tag, "_ctrl"},  32'h10, 1'b1, 32'd0, 32'd0);
    endtask

    // ---------------- stimulus
    initial begin
        rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state and idle hold
        reset_reads("rst");
        idle(20);
        rd_exp("idle_lo", 32'h00, 1'b1, 32'd0, 32'd0);
        rd_exp("idle_hi", 32'h04, 1'b1, 32'd0, 32'd0);

        // decode: deselected and reserved writes, reserved and deselected reads, aliasing
        op(1'b0, 1'b1, 32'h00, 32'h1234_5678, 4'hF);
        wr(32'h14, 32'hFFFF_FFFF, 4'hF);
        wr(32'h1C, 32'hFFFF_FFFF, 4'hF);
        rd_exp("res_14", 32'h14, 1'b1, 32'd0, 32'd0);
        rd_exp("res_18", 32'h18, 1'b1, 32'd0, 32'd0);
        rd_exp("res_1c", 32'h1C, 1'b1, 32'd0, 32'd0);
        rd_exp("nosel",  32'h08, 1'b0, 32'd0, 32'd0);
        rd_exp("dec_lo", 32'h00, 1'b1, 32'd0, 32'd0);
        rd_exp("dec_ctrl", 32'h10, 1'b1, 32'd0, 32'd0);
        rd_exp("alias_cmp", 32'hABC0_0008, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // prescaler timing
        wr(32'h10, 32'd1, 4'h1);
        idle(4);
        rd_exp("pre_4edges", 32'h00, 1'b1, 32'd1, 32'd4);
        idle(15);
        rd_exp("pre_20edges", 32'h00, 1'b1, 32'd5, 32'd20);
        wr(32'h10, 32'd0, 4'h1);
        idle(5);
        rd_exp("pre_frozen", 32'h00, 1'b1, 32'd5, 32'd22);
        wr(32'h10, 32'd1, 4'h1);
        idle(3);
        rd_exp("pre_reen3", 32'h00, 1'b1, 32'd5, 32'd25);
        rd_exp("pre_reen4", 32'h00, 1'b1, 32'd6, 32'd26);
        wr(32'h10, 32'd0, 4'h1);

        // carry from LO into HI
        wr(32'h00, 32'hFFFF_FFFF, 4'hF);
        wr(32'h04, 32'h0000_0000, 4'hF);
        wr(32'h10, 32'd1, 4'h1);
        rd_exp("carry_hi0", 32'h04, 1'b1, 32'd0, 32'd0);
        rd_exp("carry_hi1", 32'h04, 1'b1, 32'd0, 32'd1);
        rd_exp("carry_lo",  32'h00, 1'b1, 32'hFFFF_FFFF, 32'd1);
        wr(32'h10, 32'd0, 4'h1);

        // 64-bit wrap
        wr(32'h00, 32'hFFFF_FFFF, 4'hF);
        wr(32'h04, 32'hFFFF_FFFF, 4'hF);
        wr(32'h10, 32'd1, 4'h1);
        idle(4);
        rd_exp("wrap_lo", 32'h00, 1'b1, 32'd0, 32'd3);
        rd_exp("wrap_hi", 32'h04, 1'b1, 32'd0, 32'd0);
        wr(32'h10, 32'd0, 4'h1);

        // write/tick collision with partial strobe
        wr(32'h00, 32'h0000_0100, 4'hF);
        wr(32'h04, 32'h0000_0005, 4'hF);
        wr(32'h10, 32'd1, 4'h1);
        wr(32'h00, 32'h0000_0010, 4'b0001);
        rd_exp("coll_lo", 32'h00, 1'b1, 32'h0000_0110, 32'h0000_0110);
        rd_exp("coll_hi", 32'h04, 1'b1, 32'd5, 32'd5);
        wr(32'h10, 32'd0, 4'h1);

        // interrupt rise and fall
        wr(32'h00, 32'd0, 4'hF);
        wr(32'h04, 32'd0, 4'hF);
        wr(32'h0C, 32'hFFFF_FFFF, 4'hF);
        wr(32'h08, 32'd10, 4'hF);
        wr(32'h0C, 32'd0, 4'hF);
        wr(32'h10, 32'd1, 4'h1);
        idle(10);
        chk_mtip("irq_at10", 1'b0, 1'b0);
        idle(1);
        chk_mtip("irq_rise", 1'b0, 1'b1);
        wr(32'h08, 32'd100, 4'hF);
        chk_mtip("irq_hold", 1'b0, 1'b1);
        idle(1);
        chk_mtip("irq_fall", 1'b0, 1'b0);
        wr(32'h08, 32'd0, 4'hF);
        idle(1);
        chk_mtip("irq_both", 1'b1, 1'b1);

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk_mtip("async_rst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_reads("rst2");

        // randomized traffic against the model
        wr(32'h08, 32'd40, 4'hF);
        wr(32'h0C, 32'd0, 4'hF);
        wr(32'h10, 32'd1, 4'h1);
        for (int n = 0; n < 400; n++) begin
            int          r;
            logic [31:0] tmp, a, d;
            logic [2:0]  ix;
            r   = int'($urandom_range(0, 9));
            tmp = $urandom;
            ix  = 3'($urandom_range(0, 7));
            a   = {tmp[31:5], ix, tmp[1:0]};
            d   = $urandom;
            if (ix == 3'd4)              d[0] = ($urandom_range(0, 3) != 0);
            else if (ix != 3'd1 && ix != 3'd3) d = d & 32'h0000_00FF;
            else                         d = 32'd0;
            if (r < 4)      rd("rnd", a, ($urandom_range(0, 7) != 0));
            else if (r < 6) idle(1);
            else            wr(a, d, 4'($urandom));
        end

        idle(2);
        check("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
